// File: rtl/fpdiv_pkg.sv
// Shared constants and helpers for the iterative restoring divider.
// Holds legal radices, the per-cycle bit count, iteration count and lzcnt width.
package fpdiv_pkg;

    localparam int RADIX2 = 2;
    localparam int RADIX4 = 4;
    localparam int RADIX8 = 8;

    localparam int LZW = 8;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    function automatic int radix_bits(input int radix);
        return (radix == RADIX8) ? 3 :
               (radix == RADIX4) ? 2 : 1;
    endfunction

    function automatic int iter_count(input int wid, input int k);
        return (2 * wid + k - 1) / k;
    endfunction

endpackage

// File: rtl/fpdiv_stage.sv
// One radix-2 restoring division step (combinational).
// Ports: rin/din partial remainder and next dividend bit, d divisor; rout, qb results.
module fpdiv_stage #(
    parameter int WID = 8
) (
    input  logic [WID-1:0] rin,
    input  logic           din,
    input  logic [WID-1:0] d,
    output logic [WID-1:0] rout,
    output logic           qb
);

    logic [WID:0]   t;
    logic [WID-1:0] diff;

    assign t    = {rin, din};
    // rin < d, so t - d < d and fits WID bits; modular subtract is exact
    assign diff = t[WID-1:0] - d;
    assign qb   = (t >= {1'b0, d});
    assign rout = qb ? diff : t[WID-1:0];

endmodule

// File: rtl/fpdiv_iter.sv
// Iterative restoring divider: q = floor(a*2^WID/b), r = remainder, k bits/cycle.
// Ports: clk, rst (async high), ld, a, b in; q, r, busy, done, dbz, lzcnt out.
// Option: FPDIV_LZCNT_EN enables the leading-zero count of q on lzcnt.
module fpdiv_iter #(
    parameter int WID   = 112,
    parameter int RADIX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WID-1:0]   a,
    input  logic [WID-1:0]   b,
    output logic [2*WID-1:0] q,
    output logic [WID-1:0]   r,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [7:0]       lzcnt
);

    import fpdiv_pkg::*;

    localparam int QW = 2 * WID;
    localparam int K  = radix_bits(RADIX);
    localparam int N  = iter_count(WID, K);
    // bits retired by the final, possibly shorter, iteration
    localparam int LK = QW - (N - 1) * K;
    localparam logic [7:0] NM1 = 8'(N - 1);

    state_t state_q, state_d;

    logic [QW-1:0]  dvd_q, q_q;
    logic [WID-1:0] r_q, b_q;
    logic [7:0]     cnt_q;
    logic           done_q, dbz_q;

    logic [QW-1:0]  src_dvd, src_q;
    logic [WID-1:0] src_r, src_b;
    logic [WID-1:0] rc [0:K];
    logic [K-1:0]   qb;
    logic [QW+K-1:0] q_cat;
    logic [QW-1:0]  q_step, dvd_step;
    logic [WID-1:0] r_step;
    logic           run, last, special;

    assign run     = (state_q == RUN);
    assign last    = run && !ld && (cnt_q == NM1);
    assign special = (b == '0) || (a == '0);

    // the ld edge itself performs iteration 0 from the live operands
    always_comb begin
        src_r   = r_q;
        src_q   = q_q;
        src_dvd = dvd_q;
        src_b   = b_q;
        if (ld) begin
            src_r   = '0;
            src_q   = '0;
            src_dvd = {a, {WID{1'b0}}};
            src_b   = b;
        end
    end

    assign rc[0] = src_r;

    for (genvar i = 0; i < K; i++) begin : g_chain
        fpdiv_stage #(.WID(WID)) u_stage (
            .rin  (rc[i]),
            .din  (src_dvd[QW-1-i]),
            .d    (src_b),
            .rout (rc[i+1]),
            .qb   (qb[K-1-i])
        );
    end

    // final iteration keeps only the top LK quotient bits of the chain
    assign q_cat    = {src_q, qb};
    assign q_step   = last ? q_cat[QW-1+K-LK -: QW] : q_cat[QW-1:0];
    assign r_step   = last ? rc[LK] : rc[K];
    assign dvd_step = src_dvd << K;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ld)        state_d = special ? IDLE : RUN;
        else if (last) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= '0;
            r_q    <= '0;
            dvd_q  <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ld) begin
                cnt_q <= 8'd1;
                dbz_q <= 1'b0;
                if (b == '0) begin
                    q_q    <= '1;
                    r_q    <= '0;
                    dbz_q  <= 1'b1;
                    done_q <= 1'b1;
                end else if (a == '0) begin
                    q_q    <= '0;
                    r_q    <= '0;
                    done_q <= 1'b1;
                end else begin
                    q_q   <= q_step;
                    r_q   <= r_step;
                    dvd_q <= dvd_step;
                    b_q   <= b;
                end
            end else if (run) begin
                q_q    <= q_step;
                r_q    <= r_step;
                dvd_q  <= dvd_step;
                cnt_q  <= cnt_q + 8'd1;
                done_q <= last;
            end
        end
    end

    assign q    = q_q;
    assign r    = r_q;
    assign busy = run;
    assign done = done_q;
    assign dbz  = dbz_q;

`ifdef FPDIV_LZCNT_EN
    function automatic logic [LZW-1:0] clz(input logic [QW-1:0] v);
        logic [LZW-1:0] n;
        logic           hit;
        n   = '0;
        hit = 1'b0;
        for (int i = QW - 1; i >= 0; i--) begin
            if (v[i])      hit = 1'b1;
            else if (!hit) n = n + LZW'(1);
        end
        return n;
    endfunction

    logic [LZW-1:0] lz_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       lz_q <= '0;
        else if (ld)   lz_q <= (b != '0 && a == '0) ? LZW'(QW) : '0;
        else if (last) lz_q <= clz(q_step);
    end

    assign lzcnt = lz_q;
`else
    assign lzcnt = '0;
`endif

endmodule

// File: tb/tb_fpdiv_iter.sv
// Self-checking bench for fpdiv_iter: WID=8 at RADIX 8 and RADIX 2.
// Random and directed divides against an arithmetic reference model.
module tb_fpdiv_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld8 = 1'b0, ld2 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, a2 = '0, b2 = '0;
    logic [15:0] q8, q2;
    logic [7:0]  r8, r2, lz8, lz2;
    logic        busy8, busy2, done8, done2, dbz8, dbz2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fpdiv_iter #(.WID(8), .RADIX(8)) u8 (
        .clk(clk), .rst(rst), .ld(ld8), .a(a8), .b(b8),
        .q(q8), .r(r8), .busy(busy8), .done(done8),
        .dbz(dbz8), .lzcnt(lz8)
    );

    fpdiv_iter #(.WID(8), .RADIX(2)) u2 (
        .clk(clk), .rst(rst), .ld(ld2), .a(a2), .b(b2),
        .q(q2), .r(r2), .busy(busy2), .done(done2),
        .dbz(dbz2), .lzcnt(lz2)
    );

    // reference: exact integer division, latency from bits-per-cycle
    task automatic model(input logic [7:0] aa, input logic [7:0] bb,
                         input bit s2, output logic [15:0] qe,
                         output logic [7:0] re, output logic dze,
                         output logic [7:0] lze, output int late);
        int num, k, v;
        k = s2 ? 1 : 3;
        if (bb == 0) begin
            qe = 16'hFFFF; re = 0; dze = 1; lze = 0; late = 1;
        end else begin
            num  = int'(aa) * 256;
            qe   = 16'(num / int'(bb));
            re   = 8'(num % int'(bb));
            dze  = 0;
            late = (aa == 0) ? 1 : (16 + k - 1) / k;
            lze  = 16;
            v    = int'(qe);
            while (v != 0) begin
                v   = v / 2;
                lze = lze - 1;
            end
        end
`ifndef FPDIV_LZCNT_EN
        lze = 0;
`endif
    endtask

    // called at a negedge; issues ld and observes win cycles
    task automatic run_op(input bit s2, input logic [7:0] aa,
                          input logic [7:0] bb, input int win,
                          output int dix, output int dcnt, output int bcnt,
                          output logic [15:0] qq, output logic [7:0] rr,
                          output logic dz, output logic [7:0] lz,
                          output bit held);
        dix = -1; dcnt = 0; bcnt = 0;
        qq = 0; rr = 0; dz = 0; lz = 0; held = 0;
        if (s2) begin ld2 = 1; a2 = aa; b2 = bb; end
        else    begin ld8 = 1; a8 = aa; b8 = bb; end
        for (int j = 1; j <= win; j++) begin
            @(negedge clk);
            if (j == 1) begin
                ld8 = 0; ld2 = 0;
                a8 = 8'($urandom); b8 = 8'($urandom);
                a2 = 8'($urandom); b2 = 8'($urandom);
            end
            if (s2 ? busy2 : busy8) bcnt++;
            if (s2 ? done2 : done8) begin
                dcnt++;
                if (dix < 0) begin
                    dix = j;
                    qq = s2 ? q2 : q8;
                    rr = s2 ? r2 : r8;
                    dz = s2 ? dbz2 : dbz8;
                    lz = s2 ? lz2 : lz8;
                end
            end
        end
        held = (dix > 0) &&
               ((s2 ? q2 : q8) === qq) && ((s2 ? r2 : r8) === rr) &&
               ((s2 ? dbz2 : dbz8) === dz) && ((s2 ? lz2 : lz8) === lz);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp++; if ({q8, r8} !== 24'h0) begin n_bad++;
            $display("FAIL reset_qr8: got %h want 0", {q8, r8}); end
        n_cmp++; if ({busy8, done8, dbz8, lz8} !== 11'h0) begin n_bad++;
            $display("FAIL reset_flags8: got %h want 0", {busy8, done8, dbz8, lz8}); end
        n_cmp++; if ({q2, r2} !== 24'h0) begin n_bad++;
            $display("FAIL reset_qr2: got %h want 0", {q2, r2}); end
        n_cmp++; if ({busy2, done2, dbz2, lz2} !== 11'h0) begin n_bad++;
            $display("FAIL reset_flags2: got %h want 0", {busy2, done2, dbz2, lz2}); end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_divide(input int nrand);
        logic [7:0]  ta [4] = '{8'h80, 8'hFF, 8'h55, 8'h00};
        logic [7:0]  tb [4] = '{8'h03, 8'hFF, 8'h00, 8'h07};
        bit          ts [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0]  aa, bb, re, rr, lze, lz;
        logic [15:0] qe, qq;
        logic        dze, dz;
        bit          s2, held;
        int          late, dix, dcnt, bcnt;
        for (int i = 0; i < 4 + nrand; i++) begin
            if (i < 4) begin
                aa = ta[i]; bb = tb[i]; s2 = ts[i];
            end else begin
                aa = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
                bb = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
                s2 = 1'($urandom);
            end
            model(aa, bb, s2, qe, re, dze, lze, late);
            run_op(s2, aa, bb, late + 4, dix, dcnt, bcnt, qq, rr, dz, lz, held);
            n_cmp++; if (dix !== late) begin n_bad++;
                $display("FAIL div%0d_latency: got %0d want %0d", i, dix, late); end
            n_cmp++; if (dcnt !== 1) begin n_bad++;
                $display("FAIL div%0d_done_count: got %0d want 1", i, dcnt); end
            n_cmp++; if (bcnt !== late - 1) begin n_bad++;
                $display("FAIL div%0d_busy_cycles: got %0d want %0d", i, bcnt, late - 1); end
            n_cmp++; if (qq !== qe) begin n_bad++;
                $display("FAIL div%0d_q a=%h b=%h: got %h want %h", i, aa, bb, qq, qe); end
            n_cmp++; if (rr !== re) begin n_bad++;
                $display("FAIL div%0d_r a=%h b=%h: got %h want %h", i, aa, bb, rr, re); end
            n_cmp++; if (dz !== dze) begin n_bad++;
                $display("FAIL div%0d_dbz: got %b want %b", i, dz, dze); end
            n_cmp++; if (lz !== lze) begin n_bad++;
                $display("FAIL div%0d_lzcnt: got %0d want %0d", i, lz, lze); end
            n_cmp++; if (held !== 1'b1) begin n_bad++;
                $display("FAIL div%0d_hold: got %b want 1", i, held); end
        end
    endtask

    task automatic test_abort;
        logic [7:0]  re, rr, lze, lz;
        logic [15:0] qe, qq;
        logic        dze, dz;
        bit          held;
        int          late, dix, dcnt, bcnt;
        ld8 = 1; a8 = 8'h80; b8 = 8'h03;
        @(negedge clk);
        ld8 = 0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy8 !== 1'b1) begin n_bad++;
            $display("FAIL abort_busy_before: got %b want 1", busy8); end
        model(8'hC5, 8'h0B, 1'b0, qe, re, dze, lze, late);
        run_op(1'b0, 8'hC5, 8'h0B, 12, dix, dcnt, bcnt, qq, rr, dz, lz, held);
        n_cmp++; if (dcnt !== 1) begin n_bad++;
            $display("FAIL abort_done_count: got %0d want 1", dcnt); end
        n_cmp++; if (dix !== 6) begin n_bad++;
            $display("FAIL abort_latency: got %0d want 6", dix); end
        n_cmp++; if ({qq, rr} !== {qe, re}) begin n_bad++;
            $display("FAIL abort_result: got %h want %h", {qq, rr}, {qe, re}); end
        n_cmp++; if (lz !== lze) begin n_bad++;
            $display("FAIL abort_lzcnt: got %0d want %0d", lz, lze); end
    endtask

    task automatic test_reset_mid;
        logic [7:0]  re, rr, lze, lz;
        logic [15:0] qe, qq;
        logic        dze, dz;
        bit          held;
        int          late, dix, dcnt, bcnt, spur;
        ld8 = 1; a8 = 8'hE7; b8 = 8'h05;
        @(negedge clk);
        ld8 = 0;
        @(negedge clk);
        #2 rst = 1;
        #1;
        n_cmp++; if ({q8, r8, busy8, done8, dbz8, lz8} !== 35'h0) begin n_bad++;
            $display("FAIL rstmid_outputs: got %h want 0",
                     {q8, r8, busy8, done8, dbz8, lz8}); end
        ld8 = 1; a8 = 8'h11; b8 = 8'h00;
        @(negedge clk);
        ld8 = 0; rst = 0;
        spur = 0;
        repeat (10) begin
            @(negedge clk);
            if (done8 || busy8) spur++;
        end
        n_cmp++; if (spur !== 0) begin n_bad++;
            $display("FAIL rstmid_no_done: got %0d want 0", spur); end
        model(8'h9A, 8'h37, 1'b0, qe, re, dze, lze, late);
        run_op(1'b0, 8'h9A, 8'h37, late + 4, dix, dcnt, bcnt, qq, rr, dz, lz, held);
        n_cmp++; if (dix !== late || dcnt !== 1) begin n_bad++;
            $display("FAIL rstmid_after_timing: got %0d/%0d want %0d/1", dix, dcnt, late); end
        n_cmp++; if ({qq, rr, dz, lz} !== {qe, re, dze, lze}) begin n_bad++;
            $display("FAIL rstmid_after_result: got %h want %h",
                     {qq, rr, dz, lz}, {qe, re, dze, lze}); end
    endtask

    initial begin
        test_reset();
        test_divide(40);
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
